// File: rtl/clock_div_pkg.sv
// Shared types and constants for the divider clock-slice control logic.
// State encoding plus the divide-by-1 ratio used out of reset.
package clock_div_pkg;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_PREQ,
        ST_ENA,
        ST_RUN,
        ST_UPD_H,
        ST_UPD_L,
        ST_DIS,
        ST_PREL
    } state_t;

    localparam int MF_W_DEF = 8;

    localparam int RST_MFI = 1;
    localparam int RST_MFN = 0;
    localparam int RST_MFD = 1;

endpackage

// File: rtl/clock_control_logic_div_mc_if.sv
// Ratio programming handshake and divider macro link.
// master = control logic, slave = config source / hard macro side.
interface clock_control_logic_div_mc_if
    import clock_div_pkg::*;
#(
    parameter int MF_W = MF_W_DEF
) ();

    logic            cfg_valid;
    logic            cfg_ready;
    logic [MF_W-1:0] cfg_mfi;
    logic [MF_W-1:0] cfg_mfn;
    logic [MF_W-1:0] cfg_mfd;
    logic [MF_W-1:0] mfi;
    logic [MF_W-1:0] mfn;
    logic [MF_W-1:0] mfd;
    logic            async_update;
    logic            async_update_ack;
    logic            async_enable;
    logic            async_enable_ack;

    modport master (
        input  cfg_valid, cfg_mfi, cfg_mfn, cfg_mfd,
        input  async_update_ack, async_enable_ack,
        output cfg_ready, mfi, mfn, mfd,
        output async_update, async_enable
    );

    modport slave (
        output cfg_valid, cfg_mfi, cfg_mfn, cfg_mfd,
        output async_update_ack, async_enable_ack,
        input  cfg_ready, mfi, mfn, mfd,
        input  async_update, async_enable
    );

endinterface

// File: rtl/clock_sync_bit.sv
// Multi-flop synchroniser for one asynchronous acknowledge bit.
// Clears to 0 on reset so the FSM never sees a stale ack.
module clock_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    // shift the async input through the flop chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[STAGES-2:0], d};
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/clock_control_logic_div_mc.sv
// Divider clock-slice control: parent/child handshake fan-out,
// glitch-free ratio reprogramming and ack watchdog.
module clock_control_logic_div_mc
    import clock_div_pkg::*;
#(
    parameter int NUM_CHILD   = 4,
    parameter int MF_W        = MF_W_DEF,
    parameter int ACK_TIMEOUT = 1023,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clock,
    input  logic                 async_resetn,
    output logic                 parent_request,
    input  logic                 parent_ready,
    input  logic                 parent_silent,
    input  logic                 parent_starting,
    input  logic                 parent_stopping,
    input  logic [NUM_CHILD-1:0] child_request,
    output logic [NUM_CHILD-1:0] child_ready,
    output logic [NUM_CHILD-1:0] child_silent,
    output logic [NUM_CHILD-1:0] child_starting,
    output logic [NUM_CHILD-1:0] child_stopping,
    clock_control_logic_div_mc_if.master bus,
    output logic                 err_timeout
);

    localparam int WD_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(ACK_TIMEOUT - 1);

    state_t          state;
    state_t          state_nx;
    logic [WD_W-1:0] wd_cnt;
    logic            en_ack_s;
    logic            upd_ack_s;
    logic            demand;
    logic            accept;
    logic            cfg_pending;
    logic            cfg_rdy_q;
    logic            wd_timed;
    logic            wd_fire;
    logic            go_upd;
    logic            pend_keep;
    logic            unused_status;

    clock_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_en (
        .clk   (clock),
        .rst_n (async_resetn),
        .d     (bus.async_enable_ack),
        .q     (en_ack_s)
    );

    clock_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_upd (
        .clk   (clock),
        .rst_n (async_resetn),
        .d     (bus.async_update_ack),
        .q     (upd_ack_s)
    );

    assign demand        = |child_request;
    assign unused_status = parent_silent ^ parent_starting;
    assign accept        = bus.cfg_valid & cfg_rdy_q;
    assign wd_timed      = state inside {ST_ENA, ST_UPD_H, ST_UPD_L, ST_DIS};
    assign pend_keep     = state inside {ST_ENA, ST_RUN, ST_DIS};

    // next-state decode; watchdog overrides a stalled ack wait
    always_comb begin
        state_nx = state;
        go_upd   = 1'b0;
        wd_fire  = 1'b0;
        unique case (state)
            ST_OFF:   if (demand) state_nx = ST_PREQ;
            ST_PREQ: begin
                if (parent_ready) state_nx = ST_ENA;
                else if (!demand) state_nx = ST_OFF;
            end
            ST_ENA:   if (en_ack_s) state_nx = ST_RUN;
            ST_RUN: begin
                if (cfg_pending) begin
                    state_nx = ST_UPD_H;
                    go_upd   = 1'b1;
                end else if (!demand || parent_stopping || !parent_ready) begin
                    state_nx = ST_DIS;
                end
            end
            ST_UPD_H: if (upd_ack_s) state_nx = ST_UPD_L;
            ST_UPD_L: if (!upd_ack_s) state_nx = ST_RUN;
            ST_DIS:   if (!en_ack_s) state_nx = ST_PREL;
            ST_PREL:  if (!parent_ready) state_nx = ST_OFF;
            default:  state_nx = ST_OFF;
        endcase
        if (wd_timed && state_nx == state && wd_cnt == WD_LAST) begin
            wd_fire  = 1'b1;
            state_nx = ST_PREL;
        end
    end

    // state, watchdog counter, sticky error and cfg_ready register
    always_ff @(posedge clock or negedge async_resetn) begin
        if (!async_resetn) begin
            state       <= ST_OFF;
            wd_cnt      <= '0;
            err_timeout <= 1'b0;
            cfg_rdy_q   <= 1'b0;
        end else begin
            state     <= state_nx;
            cfg_rdy_q <= !(state_nx inside {ST_UPD_H, ST_UPD_L});
            if (state_nx != state) wd_cnt <= '0;
            else if (wd_timed)     wd_cnt <= wd_cnt + 1'b1;
            if (wd_fire) err_timeout <= 1'b1;
        end
    end

    // ratio registers; a pending update is only kept while enabled
    always_ff @(posedge clock or negedge async_resetn) begin
        if (!async_resetn) begin
            bus.mfi     <= MF_W'(RST_MFI);
            bus.mfn     <= MF_W'(RST_MFN);
            bus.mfd     <= MF_W'(RST_MFD);
            cfg_pending <= 1'b0;
        end else begin
            if (accept) begin
                bus.mfi <= bus.cfg_mfi;
                bus.mfn <= bus.cfg_mfn;
                bus.mfd <= (bus.cfg_mfd == '0) ? MF_W'(1) : bus.cfg_mfd;
            end
            if (go_upd || !pend_keep) cfg_pending <= 1'b0;
            else if (accept)          cfg_pending <= 1'b1;
        end
    end

    assign bus.cfg_ready    = cfg_rdy_q;
    assign bus.async_update = (state == ST_UPD_H);
    assign bus.async_enable = state inside {ST_ENA, ST_RUN, ST_UPD_H, ST_UPD_L};
    assign parent_request   = !(state inside {ST_OFF, ST_PREL});

    assign child_ready    = {NUM_CHILD{state inside {ST_RUN, ST_UPD_H, ST_UPD_L}}};
    assign child_silent   = {NUM_CHILD{state == ST_OFF}};
    assign child_starting = {NUM_CHILD{state inside {ST_PREQ, ST_ENA}}};
    assign child_stopping = {NUM_CHILD{state inside {ST_DIS, ST_PREL}}};

endmodule

// File: tb/tb_clock_control_logic_div_mc.sv
// Bench for clock_control_logic_div_mc: directed scenarios plus
// randomized traffic against a phase-level reference model.
module tb_clock_control_logic_div_mc;

    localparam int NC = 4;
    localparam int MW = 8;
    localparam int TO = 15;
    localparam int SS = 2;

    logic          clock = 1'b0;
    logic          async_resetn;
    logic          parent_request;
    logic          parent_ready;
    logic          parent_silent;
    logic          parent_starting;
    logic          parent_stopping;
    logic [NC-1:0] child_request;
    logic [NC-1:0] child_ready;
    logic [NC-1:0] child_silent;
    logic [NC-1:0] child_starting;
    logic [NC-1:0] child_stopping;
    logic          err_timeout;

    clock_control_logic_div_mc_if #(.MF_W(MW)) bus ();

    clock_control_logic_div_mc #(
        .NUM_CHILD   (NC),
        .MF_W        (MW),
        .ACK_TIMEOUT (TO),
        .SYNC_STAGES (SS)
    ) dut (
        .clock           (clock),
        .async_resetn    (async_resetn),
        .parent_request  (parent_request),
        .parent_ready    (parent_ready),
        .parent_silent   (parent_silent),
        .parent_starting (parent_starting),
        .parent_stopping (parent_stopping),
        .child_request   (child_request),
        .child_ready     (child_ready),
        .child_silent    (child_silent),
        .child_starting  (child_starting),
        .child_stopping  (child_stopping),
        .bus             (bus),
        .err_timeout     (err_timeout)
    );

    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_on  = 0;
    bit env_on  = 0;
    bit rnd     = 0;
    bit macro_dead = 0;

    // phase-level reference model
    typedef enum {M_IDLE, M_REQ, M_BRING, M_ON, M_SWH, M_SWL, M_DOWN, M_REL} mph_t;
    mph_t          m_ph;
    int            m_t;
    bit            m_pend;
    bit            m_err;
    bit            m_fresh;
    logic [MW-1:0] m_mfi;
    logic [MW-1:0] m_mfn;
    logic [MW-1:0] m_mfd;
    bit            m_en_h[$];
    bit            m_up_h[$];

    task automatic model_reset();
        m_ph = M_IDLE;
        m_t = 0;
        m_pend = 0;
        m_err = 0;
        m_fresh = 1;
        m_mfi = MW'(1);
        m_mfn = MW'(0);
        m_mfd = MW'(1);
        m_en_h.delete();
        m_up_h.delete();
        for (int i = 0; i < SS; i++) begin
            m_en_h.push_back(1'b0);
            m_up_h.push_back(1'b0);
        end
    endtask

    task automatic model_step();
        mph_t nx;
        bit ens, ups, dem, acc, lost;
        ens  = m_en_h[0];
        ups  = m_up_h[0];
        dem  = (child_request != '0);
        lost = parent_stopping || !parent_ready;
        acc  = bus.cfg_valid && !m_fresh && !(m_ph inside {M_SWH, M_SWL});
        nx = m_ph;
        case (m_ph)
            M_IDLE:  if (dem) nx = M_REQ;
            M_REQ:   if (parent_ready) nx = M_BRING; else if (!dem) nx = M_IDLE;
            M_BRING: if (ens) nx = M_ON;
            M_ON:    if (m_pend) nx = M_SWH; else if (!dem || lost) nx = M_DOWN;
            M_SWH:   if (ups) nx = M_SWL;
            M_SWL:   if (!ups) nx = M_ON;
            M_DOWN:  if (!ens) nx = M_REL;
            default: if (!parent_ready) nx = M_IDLE;
        endcase
        if (nx == m_ph && (m_ph inside {M_BRING, M_SWH, M_SWL, M_DOWN})
            && m_t + 1 == TO) begin
            nx = M_REL;
            m_err = 1;
        end
        if (acc) begin
            m_mfi = bus.cfg_mfi;
            m_mfn = bus.cfg_mfn;
            m_mfd = (bus.cfg_mfd == '0) ? MW'(1) : bus.cfg_mfd;
        end
        if (nx == M_SWH || (m_ph inside {M_IDLE, M_REQ, M_REL, M_SWH, M_SWL}))
            m_pend = 0;
        else if (acc)
            m_pend = 1;
        m_t = (nx == m_ph) ? m_t + 1 : 0;
        m_fresh = 0;
        m_en_h.push_back(bus.async_enable_ack);
        void'(m_en_h.pop_front());
        m_up_h.push_back(bus.async_update_ack);
        void'(m_up_h.pop_front());
        m_ph = nx;
    endtask

    function automatic logic [44:0] m_vec();
        logic pr, rdy, sil, sta, sto, cr, up, en;
        pr  = !(m_ph inside {M_IDLE, M_REL});
        rdy = m_ph inside {M_ON, M_SWH, M_SWL};
        sil = (m_ph == M_IDLE);
        sta = m_ph inside {M_REQ, M_BRING};
        sto = m_ph inside {M_DOWN, M_REL};
        cr  = !m_fresh && !(m_ph inside {M_SWH, M_SWL});
        up  = (m_ph == M_SWH);
        en  = m_ph inside {M_BRING, M_ON, M_SWH, M_SWL};
        return {pr, {NC{rdy}}, {NC{sil}}, {NC{sta}}, {NC{sto}}, cr,
                m_mfi, m_mfn, m_mfd, up, en, m_err};
    endfunction

    function automatic logic [44:0] dut_vec();
        return {parent_request, child_ready, child_silent, child_starting,
                child_stopping, bus.cfg_ready, bus.mfi, bus.mfn, bus.mfd,
                bus.async_update, bus.async_enable, err_timeout};
    endfunction

    // per-cycle comparison of every output against the model
    always @(negedge clock) begin
        if (chk_on) begin
            n_total++;
            if (dut_vec() === m_vec()) n_pass++;
            else $display("FAIL cycle_model t=%0t dut=%h model=%h",
                          $time, dut_vec(), m_vec());
        end
    end

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s got %0h want %0h", name, act, exp);
    endtask

    // parent and macro responders
    task automatic env_react();
        bit go;
        go = !rnd || ($urandom_range(2) == 0);
        if (go && parent_ready != parent_request)
            parent_ready = parent_request;
        else if (rnd && parent_ready && $urandom_range(80) == 0)
            parent_ready = 1'b0;
        go = !rnd || ($urandom_range(2) == 0);
        if (go && !macro_dead && bus.async_enable_ack != bus.async_enable)
            bus.async_enable_ack = bus.async_enable;
        go = !rnd || ($urandom_range(2) == 0);
        if (go && bus.async_update_ack != bus.async_update)
            bus.async_update_ack = bus.async_update;
        parent_stopping = rnd && ($urandom_range(40) == 0);
        parent_silent   = !parent_ready;
        parent_starting = parent_request && !parent_ready;
    endtask

    task automatic tick();
        @(posedge clock);
        if (async_resetn) model_step();
        @(negedge clock);
        if (env_on) env_react();
    endtask

    initial begin
        int n;
        int rises;
        bit held;
        bit prev;
        async_resetn = 1'b1;
        parent_ready = 0;
        parent_silent = 1;
        parent_starting = 0;
        parent_stopping = 0;
        child_request = '0;
        bus.cfg_valid = 0;
        bus.cfg_mfi = '0;
        bus.cfg_mfn = '0;
        bus.cfg_mfd = '0;
        bus.async_update_ack = 0;
        bus.async_enable_ack = 0;
        #1 async_resetn = 1'b0;
        model_reset();
        chk_on = 1;
        #1;
        check("rst_outputs", dut_vec(),
              {1'b0, 4'h0, 4'hf, 4'h0, 4'h0, 1'b0, 8'd1, 8'd0, 8'd1,
               1'b0, 1'b0, 1'b0});
        @(negedge clock);
        tick();
        async_resetn = 1'b1;
        tick();
        check("rst_cfg_ready", {bus.cfg_ready, child_silent}, 5'h1f);

        // 1: bring-up with fixed parent/macro delays
        child_request = 4'b0100;
        tick();
        check("s1_preq_rise", {parent_request, child_starting}, 5'h1f);
        tick();
        tick();
        parent_ready = 1;
        parent_silent = 0;
        tick();
        check("s1_ena", bus.async_enable, 1);
        for (int i = 0; i < 4; i++) tick();
        bus.async_enable_ack = 1;
        tick();
        tick();
        check("s1_ready_wait", child_ready, 4'h0);
        tick();
        check("s1_ready", child_ready, 4'hf);

        // 2: single reprogram while running
        env_on = 1;
        check("s2_cfg_ready", bus.cfg_ready, 1);
        bus.cfg_valid = 1;
        bus.cfg_mfi = 8'd3;
        bus.cfg_mfn = 8'd1;
        bus.cfg_mfd = 8'd4;
        tick();
        bus.cfg_valid = 0;
        check("s2_ratio", {bus.mfi, bus.mfn, bus.mfd}, 24'h030104);
        check("s2_no_upd_yet", bus.async_update, 0);
        tick();
        check("s2_upd_rise", {bus.async_update, bus.cfg_ready}, 2'b10);
        held = 1;
        n = 0;
        while (!bus.cfg_ready && n < 40) begin
            if (child_ready != 4'hf) held = 0;
            tick();
            n++;
        end
        check("s2_ready_held", {held, child_ready}, 5'h1f);
        check("s2_ack_low", {bus.cfg_ready, bus.async_update_ack}, 2'b10);

        // 3: back-to-back accepts give one update, last value wins
        bus.cfg_valid = 1;
        bus.cfg_mfi = 8'd5;
        bus.cfg_mfn = 8'd2;
        bus.cfg_mfd = 8'd2;
        tick();
        bus.cfg_mfi = 8'd7;
        bus.cfg_mfn = 8'd0;
        bus.cfg_mfd = 8'd0;
        tick();
        bus.cfg_valid = 0;
        check("s3_last_wins", {bus.mfi, bus.mfn, bus.mfd}, 24'h070001);
        rises = bus.async_update ? 1 : 0;
        prev = bus.async_update;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.async_update && !prev) rises++;
            prev = bus.async_update;
        end
        check("s3_one_update", rises, 1);

        // 4: all demand drops
        child_request = '0;
        tick();
        check("s4_dis", {bus.async_enable, parent_request, child_stopping},
              6'b01_1111);
        n = 0;
        while (parent_request && n < 20) begin
            tick();
            n++;
        end
        check("s4_prel", {parent_request, child_stopping}, 5'h0f);
        n = 0;
        while (child_silent != 4'hf && n < 20) begin
            tick();
            n++;
        end
        check("s4_silent", child_silent, 4'hf);

        // 5: enable ack never arrives
        macro_dead = 1;
        child_request = 4'b0001;
        n = 0;
        while (!bus.async_enable && n < 20) begin
            tick();
            n++;
        end
        n = 0;
        while (!err_timeout && n < 40) begin
            if (bus.async_enable) n++;
            tick();
        end
        check("s5_timeout_cycles", n, TO);
        check("s5_prel", {err_timeout, bus.async_enable, parent_request}, 3'b100);
        child_request = '0;
        tick();
        tick();
        tick();
        check("s5_sticky", {err_timeout, child_silent}, 5'h1f);

        // 6: reset in the middle of an update handshake
        macro_dead = 0;
        child_request = 4'b1000;
        n = 0;
        while (child_ready != 4'hf && n < 40) begin
            tick();
            n++;
        end
        bus.cfg_valid = 1;
        bus.cfg_mfi = 8'd9;
        bus.cfg_mfn = 8'd0;
        bus.cfg_mfd = 8'd3;
        tick();
        bus.cfg_valid = 0;
        tick();
        check("s6_in_upd", {bus.async_update, err_timeout, bus.mfi}, 10'h309);
        #2 async_resetn = 1'b0;
        model_reset();
        child_request = '0;
        bus.async_enable_ack = 0;
        bus.async_update_ack = 0;
        #1;
        check("s6_async_rst",
              {bus.async_update, bus.async_enable, err_timeout, bus.mfi, bus.mfd},
              {3'b000, 8'd1, 8'd1});
        tick();
        tick();
        async_resetn = 1'b1;
        tick();
        check("s6_off", {parent_request, child_silent, bus.async_enable}, 6'b0_1111_0);

        // randomized traffic
        rnd = 1;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(9) == 0)
                child_request = ($urandom_range(2) == 0) ? '0 : NC'($urandom_range(15));
            bus.cfg_valid = ($urandom_range(3) == 0);
            bus.cfg_mfi = MW'($urandom);
            bus.cfg_mfn = MW'($urandom);
            bus.cfg_mfd = ($urandom_range(4) == 0) ? '0 : MW'($urandom);
            tick();
        end

        chk_on = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
